// File: rtl/mips_div_pkg.sv
// Shared types and helpers for the MIPS DIV/DIVU sequencer.
package mips_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int DIV_W = 32;

    // Magnitude of a W-bit operand; unsigned operands pass through untouched.
    // |0x80000000| stays 0x80000000, which is correct when read as unsigned.
    function automatic logic [DIV_W-1:0] abs_w(input logic [DIV_W-1:0] value,
                                               input logic             is_signed);
        if (is_signed && value[DIV_W-1])
            return ~value + 1'b1;
        else
            return value;
    endfunction

endpackage

// File: rtl/mips_div_step.sv
// One restoring-division step: shift in one dividend bit, conditionally subtract.
module div_step
    import mips_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] r,
    input  logic         a_bit,
    input  logic [W-1:0] b,
    output logic [W-1:0] r_next,
    output logic         q_bit
);

    logic [W:0] r_shift;

    // Compare at W+1 bits; the kept remainder is always below b so W bits suffice.
    always_comb begin
        r_shift = {r, a_bit};
        q_bit   = (r_shift >= {1'b0, b});
        r_next  = q_bit ? (r_shift[W-1:0] - b) : r_shift[W-1:0];
    end

endmodule

// File: rtl/mips_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer with HI/LO registers and busy interlock.
module mips_div_ctrl
    import mips_div_pkg::*;
#(
    parameter int W  = DIV_W,
    parameter int CW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic         abort,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [W-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    div_state_t    state;
    logic [CW-1:0] count;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  r_reg;
    logic          q_neg;
    logic          r_neg;

    logic [W-1:0]  r_next;
    logic          q_bit;

    div_step #(.W(W)) u_step (
        .r      (r_reg),
        .a_bit  (a_reg[count]),
        .b      (b_reg),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    // Busy covers both the iteration and the fix-up cycle.
    always_comb begin
        busy = (state != IDLE);
    end

    // Sequencer, working registers and HI/LO; abort overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            a_reg <= '0;
            b_reg <= '0;
            q_reg <= '0;
            r_reg <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                        if (start) begin
                            a_reg <= abs_w(dividend, is_signed);
                            b_reg <= abs_w(divisor, is_signed);
                            q_neg <= is_signed & (dividend[W-1] ^ divisor[W-1]);
                            r_neg <= is_signed & dividend[W-1];
                            r_reg <= '0;
                            q_reg <= '0;
                            count <= CW'(W - 1);
                            state <= ITER;
                        end
                    end
                    ITER: begin
                        r_reg        <= r_next;
                        q_reg[count] <= q_bit;
                        if (count == '0)
                            state <= FIX;
                        else
                            count <= count - 1'b1;
                    end
                    FIX: begin
                        lo    <= q_neg ? (~q_reg + 1'b1) : q_reg;
                        hi    <= r_neg ? (~r_reg + 1'b1) : r_reg;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
